// File: rtl/conv_pkg.sv
// conv_pkg: declarations shared by the convolution-window engine.
//   conv_state_e : FSM states (IDLE, MAC, POST)
//   clog2        : ceiling log2 for elaboration-time sizing
//   round_shift  : arithmetic right shift with round-half-up
//   sat_signed   : clamp a value to a signed range of the given width
// Post-processing runs on a fixed 64-bit signed type so that one set of
// helpers serves every parameterisation (ACCW and OUTW must stay <= 62).
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    POST = 2'd2
  } conv_state_e;

  localparam int unsigned WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned n;
    r = 0;
    n = 1;
    while (n < longint'(v)) begin
      n = n << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // (v + 2^(sh-1)) >>> sh; sh == 0 passes v through untouched.
  function automatic wide_t round_shift(input wide_t v, input logic [4:0] sh);
    if (sh == 5'd0) begin
      return v;
    end
    return (v + (wide_t'(1) <<< (sh - 5'd1))) >>> sh;
  endfunction

  function automatic wide_t sat_signed(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_dot_lanes.sv
// conv_dot_lanes: combinational signed LANES-way dot product.
//   a_i   : LANES packed signed DW-bit operands
//   b_i   : LANES packed signed DW-bit operands
//   sum_o : signed ACCW-bit sum of the LANES products
module conv_dot_lanes #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LANES = 5,
  parameter int unsigned ACCW  = 24
) (
  input  logic        [LANES*DW-1:0] a_i,
  input  logic        [LANES*DW-1:0] b_i,
  output logic signed [ACCW-1:0]     sum_o
);

  logic signed [2*DW-1:0] prod [LANES];

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      prod[l] = (2*DW)'($signed(a_i[l*DW +: DW])) * (2*DW)'($signed(b_i[l*DW +: DW]));
    end
  end

  always_comb begin
    logic signed [ACCW-1:0] acc;
    acc = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      acc = acc + ACCW'(prod[l]);
    end
    sum_o = acc;
  end

endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac: parametrised convolution-window multiply-accumulate.
// Captures one K*K*NCH window plus weights on START, accumulates LANES
// taps per cycle, then adds bias, round-shifts and saturates to OUTW.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   START : request, sampled only in IDLE
//   WIN   : packed signed window taps, tap t at [t*DW +: DW]
//   WGT   : packed signed weights, same packing as WIN
//   BIAS  : signed bias added after accumulation
//   SHIFT : requantisation right-shift amount (round half up)
//   BUSY  : high in MAC and POST
//   DONE  : one-cycle pulse when OUT updates
//   OUT   : signed saturated result, held until the next DONE
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv_window_mac import conv_pkg::*; #(
  parameter int unsigned DW    = 8,
  parameter int unsigned K     = 5,
  parameter int unsigned NCH   = 1,
  parameter int unsigned LANES = 5,
  parameter int unsigned ACCW  = 24,
  parameter int unsigned OUTW  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [NCH*K*K*DW-1:0]     WIN,
  input  logic [NCH*K*K*DW-1:0]     WGT,
  input  logic signed [ACCW-1:0]    BIAS,
  input  logic [4:0]                SHIFT,
  output logic                      BUSY,
  output logic                      DONE,
  output logic signed [OUTW-1:0]    OUT
);

  localparam int unsigned NTAP = NCH * K * K;
  localparam int unsigned T    = NTAP / LANES;
  localparam int unsigned JW   = (clog2(T) > 0) ? clog2(T) : 1;

  if ((NTAP % LANES) != 0) begin : g_lanes_err
    $error("conv_window_mac: LANES must divide K*K*NCH");
  end
  if (ACCW < 2*DW + clog2(NTAP)) begin : g_accw_err
    $error("conv_window_mac: ACCW too narrow for K*K*NCH products");
  end
  if (ACCW > 62 || OUTW > 62) begin : g_wide_err
    $error("conv_window_mac: ACCW and OUTW must not exceed 62");
  end

  conv_state_e              state_q, state_d;
  logic [JW-1:0]            j_q, j_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic signed [OUTW-1:0]   out_q, out_d;
  logic                     done_q, done_d;
  logic                     cap;

  logic [NTAP*DW-1:0]       win_q, wgt_q;
  logic signed [ACCW-1:0]   bias_q;
  logic [4:0]               shift_q;

  logic [LANES*DW-1:0]      win_sel, wgt_sel;
  logic signed [ACCW-1:0]   lane_sum;

  wide_t                    v_bias, v_round, v_sat, v_act;
  logic signed [OUTW-1:0]   out_post;

  // Lane group j covers taps j*LANES .. j*LANES+LANES-1.
  always_comb begin
    win_sel = win_q[j_q*(LANES*DW) +: LANES*DW];
    wgt_sel = wgt_q[j_q*(LANES*DW) +: LANES*DW];
  end

  conv_dot_lanes #(
    .DW    (DW),
    .LANES (LANES),
    .ACCW  (ACCW)
  ) u_dot (
    .a_i   (win_sel),
    .b_i   (wgt_sel),
    .sum_o (lane_sum)
  );

  always_comb begin
    v_bias  = wide_t'(acc_q) + wide_t'(bias_q);
    v_round = round_shift(v_bias, shift_q);
    v_sat   = sat_signed(v_round, OUTW);
`ifdef CONV_RELU_EN
    v_act   = (v_sat < 0) ? '0 : v_sat;
`else
    v_act   = v_sat;
`endif
    out_post = OUTW'(v_act);
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          cap     = 1'b1;
          acc_d   = '0;
          j_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + lane_sum;
        j_d   = j_q + 1'b1;
        if (j_q == JW'(T - 1)) begin
          j_d     = '0;
          state_d = POST;
        end
      end
      POST: begin
        out_d   = out_post;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      j_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Operand capture needs no reset: contents are only read after a capture.
  always_ff @(posedge CLK) begin
    if (cap) begin
      win_q   <= WIN;
      wgt_q   <= WGT;
      bias_q  <= BIAS;
      shift_q <= SHIFT;
    end
  end

  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign OUT  = out_q;

endmodule

// File: tb/tb_conv_window_mac.sv
module tb_conv_window_mac;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  // default instance: K=5, NCH=1, LANES=5 (T=5)
  logic               start0;
  logic [199:0]       win0, wgt0;
  logic signed [23:0] bias0;
  logic [4:0]         shift0;
  logic               busy0, done0;
  logic signed [7:0]  out0;

  // second instance: K=3, NCH=2, LANES=3 (T=6)
  logic               start1;
  logic [143:0]       win1, wgt1;
  logic signed [23:0] bias1;
  logic [4:0]         shift1;
  logic               busy1, done1;
  logic signed [7:0]  out1;

  int nvec = 0;
  int nerr = 0;

  conv_window_mac u_dut0 (
    .CLK   (CLK),
    .RST   (RST),
    .START (start0),
    .WIN   (win0),
    .WGT   (wgt0),
    .BIAS  (bias0),
    .SHIFT (shift0),
    .BUSY  (busy0),
    .DONE  (done0),
    .OUT   (out0)
  );

  conv_window_mac #(
    .DW    (8),
    .K     (3),
    .NCH   (2),
    .LANES (3),
    .ACCW  (24),
    .OUTW  (8)
  ) u_dut1 (
    .CLK   (CLK),
    .RST   (RST),
    .START (start1),
    .WIN   (win1),
    .WGT   (wgt1),
    .BIAS  (bias1),
    .SHIFT (shift1),
    .BUSY  (busy1),
    .DONE  (done1),
    .OUT   (out1)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill0(input int a, input int b);
    logic [7:0] a8, b8;
    a8 = 8'(a);
    b8 = 8'(b);
    for (int t = 0; t < 25; t++) begin
      win0[t*8 +: 8] = a8;
      wgt0[t*8 +: 8] = b8;
    end
  endtask

  task automatic fill1(input int a, input int b);
    logic [7:0] a8, b8;
    a8 = 8'(a);
    b8 = 8'(b);
    for (int t = 0; t < 18; t++) begin
      win1[t*8 +: 8] = a8;
      wgt1[t*8 +: 8] = b8;
    end
  endtask

  // One START pulse on the default instance; checks latency, BUSY span,
  // result and that DONE drops after one cycle.
  task automatic run0(input string tag, input int exp_out);
    int c;
    int busy_cnt;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    busy_cnt = int'(busy0);
    c = 0;
    do begin
      tick();
      c++;
      if (!done0 && busy0) busy_cnt++;
    end while (!done0 && c < 40);
    check({tag, "_lat"}, c, 6);
    check({tag, "_busy"}, busy_cnt, 6);
    check({tag, "_out"}, out0, exp_out);
    tick();
    check({tag, "_done_w"}, done0, 0);
  endtask

  task automatic count_done0(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      if (done0) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int c;

    RST = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    bias0 = '0; shift0 = '0; bias1 = '0; shift1 = '0;
    fill0(0, 0);
    fill1(0, 0);
    tick(); tick(); tick();
    check("rst_out", out0, 0);
    check("rst_done", done0, 0);
    check("rst_busy", busy0, 0);
    check("rst_busy1", busy1, 0);
    RST = 1'b0;
    tick();
    check("post_rst_done", done0, 0);

    // all-ones: 25 products of 1
    fill0(1, 1);
    run0("ones", 25);

    // 25*127*127 = 403225
    fill0(127, 127);
    run0("sat_pos", 127);
    shift0 = 5'd12;
    run0("round12", 98);

    // 25*-128*127 = -406400
    shift0 = 5'd0;
    fill0(-128, 127);
`ifdef CONV_RELU_EN
    run0("sat_neg", 0);
`else
    run0("sat_neg", -128);
`endif

    // 25 - 30 = -5; shift 1: (-5+1)>>>1 = -2
    fill0(1, 1);
    bias0 = -24'sd30;
`ifdef CONV_RELU_EN
    run0("bias_s0", 0);
    shift0 = 5'd1;
    run0("bias_s1", 0);
`else
    run0("bias_s0", -5);
    shift0 = 5'd1;
    run0("bias_s1", -2);
`endif

    // reset in third MAC cycle discards the in-flight result
    bias0 = '0;
    shift0 = '0;
    fill0(2, 1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_out", out0, 0);
    count_done0(12, cnt);
    check("midrst_nodone", cnt, 0);

    fill0(1, 1);
    run0("after_rst", 25);

    // START while busy is ignored: one DONE only
    fill0(2, 1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    count_done0(15, cnt);
    check("busy_start_cnt", cnt, 1);
    check("busy_start_out", out0, 50);

    // START held high: results every 7 cycles, WIN changes per result
    fill0(1, 1);
    start0 = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      c = 0;
      do begin
        tick();
        c++;
      end while (!done0 && c < 30);
      check($sformatf("b2b_gap%0d", r), c, (r == 0) ? 6 : 7);
      check($sformatf("b2b_out%0d", r), out0, 25 * (r + 1));
      if (r == 2) start0 = 1'b0;
      else fill0(r + 2, 1);
    end
    tick(); tick();

    // second parametrisation: 18 taps of 1, T=6
    fill1(1, 1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("k3_busy", busy1, 1);
    c = 0;
    do begin
      tick();
      c++;
    end while (!done1 && c < 40);
    check("k3_lat", c, 7);
    check("k3_out", out1, 18);
    check("k3_idle", busy1, 0);
    tick();
    check("k3_done_w", done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Parametrised convolution-window engine, successor to the fixed 5×5×8-bit window datapath of `simpleCNN`. Accepts one packed K×K×NCH window plus matching weights on a START strobe. Accumulates LANES taps per cycle, then applies bias, rounding shift and output saturation. Optionally applies ReLU. Returns one signed activation with a one-cycle DONE pulse; it is the reusable conv stage for the multi-channel CNN top.

## Interface
- `DW`, 8: signed pixel and weight width.
- `K`, 5: kernel edge size.
- `NCH`, 1: input channels.
- `LANES`, 5: taps processed per cycle. Must divide K*K*NCH.
- `ACCW`, 24: signed accumulator width. Must be ≥ 2*DW + clog2(K*K*NCH); elaboration error otherwise.
- `OUTW`, 8: signed output width.
- `CLK` input 1: single clock. All logic on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `START` input 1: request. Sampled only in IDLE.
- `WIN` input NCH*K*K*DW: window taps. Tap t = c*K*K + y*K + x sits at `[t*DW +: DW]`, signed.
- `WGT` input NCH*K*K*DW: weights, same packing as WIN.
- `BIAS` input ACCW: signed bias, added after accumulation.
- `SHIFT` input 5: arithmetic right-shift amount for requantisation.
- `BUSY` output 1: high in MAC and POST.
- `DONE` output 1: one-cycle pulse when OUT updates.
- `OUT` output OUTW: signed result. Holds until the next DONE.

## Operation
- FSM has three states: IDLE, MAC and POST.
- **IDLE:**
  - If START is high at an edge: capture WIN, WGT, BIAS and SHIFT into registers, clear the accumulator, set j=0, go to MAC.
  - Inputs need not be held after the capture edge.
- **MAC:**
  - Each edge adds the sum of LANES signed products, lane l using tap j*LANES+l, to the accumulator.
  - j increments each edge. On the edge where j = T-1 (T = K*K*NCH/LANES), go to POST.
- **POST:** one edge.
  - Compute v = acc + BIAS.
  - If SHIFT>0: v = (v + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up. SHIFT=0: no rounding.
  - Saturate v to [-2^(OUTW-1), 2^(OUTW-1)-1] and register it to OUT.
  - DONE<=1; return to IDLE.
- Products are 2*DW signed and sign-extended to ACCW. There is no internal overflow, by the ACCW constraint.
- START while BUSY is ignored; no queueing.
- DONE is high during the first IDLE cycle after POST. START sampled high in that cycle is accepted.
- RST at any time, including mid-MAC:
  - next cycle state=IDLE, j=0, acc=0;
  - OUT=0, DONE=0, BUSY=0;
  - the in-flight result is discarded.

## Timing
- Reset values: OUT=0, DONE=0, BUSY=0, state IDLE.
- START accepted at edge n gives BUSY high from after edge n through edge n+T+1.
- OUT is valid and DONE high in the cycle after edge n+T+1: latency T+1 edges. Defaults give T=5, so DONE appears 6 cycles after the START edge.
- With START held high continuously, throughput is one result every T+2 cycles (7 at defaults).
- DONE is exactly one cycle wide and never asserted in the cycle following reset.

## Configuration
- `CONV_RELU_EN` defined: after saturation, negative values clamp to 0, so OUT ∈ [0, 2^(OUTW-1)-1].
- `CONV_RELU_EN` undefined: full signed saturated range.
- Timing is identical in both builds.

## Structure
- Shared package `conv_pkg` contains:
  - FSM state enum (IDLE/MAC/POST);
  - `clog2` function;
  - `sat_signed` function (value, width);
  - the round-shift function.
- Sub-module `conv_dot_lanes` is the combinational signed LANES-way dot product (products plus adder tree). It has parameters DW, LANES, ACCW and outputs one ACCW sum.
- The top holds the FSM, capture registers, tap mux by j, accumulator and post-processing.

## Test plan
- **All-ones:** WIN=1, WGT=1 all taps, BIAS=0, SHIFT=0, START one cycle → OUT=25, DONE one cycle wide exactly 6 cycles after the START edge, BUSY high for the 6 cycles before it.
- **Positive saturation and rounding:** WIN=127, WGT=127 all taps.
  - SHIFT=0 → OUT=127 (saturated).
  - SHIFT=12 → OUT=98 ((403225+2048)>>>12).
- **Negative saturation:** WIN=-128, WGT=127, SHIFT=0 → OUT=-128; with `CONV_RELU_EN` → OUT=0.
- **Bias and negative rounding:** WIN=WGT=1, BIAS=-30.
  - SHIFT=0 → OUT=-5 (0 with ReLU).
  - SHIFT=1 → OUT=-2.
- **Reset and busy handling:**
  - RST pulsed during the 3rd MAC cycle → next cycle BUSY=0, DONE=0, OUT=0, and no DONE follows.
  - A new START with the all-ones stimulus → OUT=25.
  - A START pulse while BUSY produces no extra DONE.
- **Back-to-back and parametrisation:**
  - START held high → DONE every 7 cycles, with OUT following changing WIN values.
  - Re-run with K=3, NCH=2, LANES=3: T=6, all-ones → OUT=18, DONE 7 cycles after the START edge.
